seq_feeder: RTL
===============

SEQ_FEEDER -- requirements
Module: seq_feeder

Interface
REQ-001 Parameter WIDTH, default 10: score width; must match the PE array.
REQ-002 Parameter NUM_PE, default 16: number of PEs in the chain; equals the query length.
REQ-003 Parameter FIFO_DEPTH, default 4: reference prefetch FIFO depth (power of two, >=2).
REQ-004 Ports, in order:
- clk  input  1  system clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  one-cycle job start pulse.
- q_base  input  2  query base.
- q_valid  input  1  query base valid.
- q_ready  output  1  feeder accepts a query base.
- r_base  input  2  reference base.
- r_valid  input  1  reference base valid.
- r_last  input  1  marks the final reference base.
- r_ready  output  1  feeder accepts a reference base.
- S_out  output  2  query base to PE0 S_in.
- store_S_out  output  1  to PE0 store_S_in.
- T_out  output  2  reference base to PE0 T_in.
- init_out  output  1  to PE0 init_in.
- V_out  output  WIDTH  boundary score to PE0 V_in.
- F_out  output  WIDTH  boundary gap score to PE0 F_in.
- busy  output  1  job in progress.
- done  output  1  one-cycle job-complete pulse.
- err  output  1  sticky reference underflow flag.

Function
REQ-005 The feeder SHALL be an FSM with states IDLE, CAPTURE_Q, LOAD_Q, PREFILL, STREAM, DRAIN and DONE.
REQ-006 IDLE: outputs inactive; when start=1, go to CAPTURE_Q, clear err, zero counters and FIFO. start is ignored in any other state.
REQ-007 CAPTURE_Q: q_ready=1; each cycle with q_valid&q_ready, write q_base to buf[cnt] and increment cnt; after the NUM_PE-th handshake, q_ready=0 next cycle and go to LOAD_Q.
REQ-008 LOAD_Q: for exactly NUM_PE cycles k=0..NUM_PE-1, drive store_S_out=1 and S_out=buf[NUM_PE-1-k] (reverse order), so PE k finally holds query base k; then store_S_out=0 and go to PREFILL.
REQ-009 PREFILL: r_ready = FIFO not full and last not yet accepted; go to STREAM when the FIFO is full or an entry with r_last=1 has been accepted.
REQ-010 STREAM: every cycle pop one FIFO entry and drive T_out=base, init_out=1 (registered, one pop per cycle, no bubbles); r_ready as in REQ-009; a push and a pop in the same cycle are both allowed.
REQ-011 STREAM: when the popped entry has last=1, go to DRAIN; init_out=0 from the following cycle.
REQ-012 STREAM underflow (FIFO empty, last not yet popped): set err=1, drive init_out=0, go to DRAIN; subsequent reference bases are not accepted.
REQ-013 DRAIN: init_out=0, r_ready=0 for NUM_PE+1 cycles, then DONE.
REQ-014 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-015 V_out SHALL be constant 0; F_out SHALL be constant -(2^(WIDTH-2)) in two's complement.
REQ-016 S_out and T_out SHALL hold their last driven values when not strobed; store_S_out and init_out are never 1 in the same cycle.
REQ-017 A job with a single reference base (r_last on the first beat) SHALL stream exactly one init_out cycle.

Reset
REQ-018 When rst=1 at a clock edge, the next state is IDLE, the FIFO empties, the counters clear and every output becomes 0 (except F_out per REQ-015), including mid-job.
REQ-019 Reset SHALL override start sampled in the same cycle.

Verification
REQ-020 NUM_PE=4; query A,C,G,T (0,1,2,3) back-to-back -> store_S_out high 4 cycles with S_out 3,2,1,0; q_ready drops after 4 beats.
REQ-021 Reference of 6 bases, r_valid continuous, last on beat 6 -> init_out high exactly 6 consecutive cycles with T_out in order; done 5 cycles after init_out falls; err=0.
REQ-022 Reference with r_valid low for 6 cycles after beat 5 (FIFO_DEPTH=4) -> err=1 and init_out=0 after the buffered bases drain, then DRAIN, then done.
REQ-023 Query q_valid toggling 1,0,1,0 -> only handshaken bases are captured; LOAD_Q order is unchanged.
REQ-024 rst asserted during STREAM -> all outputs 0 the next cycle; a new start runs a clean job.
REQ-025 start pulsed during LOAD_Q -> no effect; a single-base reference -> one init_out cycle.

Source files
------------

// File: rtl/seq_feeder.sv
// Feeds a systolic PE chain: captures a query, shifts it into the chain in reverse
// order, then streams a prefetched reference sequence with per-base init strobes.
module seq_feeder #(
    parameter int WIDTH      = 10,
    parameter int NUM_PE     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       q_base,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [1:0]       r_base,
    input  logic             r_valid,
    input  logic             r_last,
    output logic             r_ready,
    output logic [1:0]       S_out,
    output logic             store_S_out,
    output logic [1:0]       T_out,
    output logic             init_out,
    output logic [WIDTH-1:0] V_out,
    output logic [WIDTH-1:0] F_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(NUM_PE + 2);
    localparam int QW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(NUM_PE - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(NUM_PE + 1);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, CAPTURE_Q, LOAD_Q, PREFILL, STREAM, DRAIN, DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] cnt;
    logic [1:0]    qbuf [NUM_PE];
    logic [1:0]    fifo_base [FIFO_DEPTH];
    logic          fifo_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic          last_acc;
    logic          fifo_full, fifo_empty, push, pop, pop_last;
    logic [QW-1:0] cap_idx, load_idx;

    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign fifo_empty = (fifo_count == '0);
    assign push       = r_valid & r_ready;
    assign pop        = (state == STREAM) && !fifo_empty;
    assign pop_last   = pop && fifo_last[rd_ptr];
    assign cap_idx    = cnt[QW-1:0];
    assign load_idx   = QW'(NUM_PE - 1) - cnt[QW-1:0];

    assign V_out = '0;
    assign F_out = {2'b11, {(WIDTH - 2){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        q_ready    = 1'b0;
        r_ready    = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CAPTURE_Q;
            end
            CAPTURE_Q: begin
                q_ready = 1'b1;
                if (q_valid && cnt == LOAD_LAST) state_next = LOAD_Q;
            end
            LOAD_Q: begin
                if (cnt == LOAD_LAST) state_next = PREFILL;
            end
            PREFILL: begin
                r_ready = !fifo_full && !last_acc;
                if (fifo_full || last_acc) state_next = STREAM;
            end
            STREAM: begin
                r_ready = !fifo_full && !last_acc;
                if (fifo_empty || pop_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload storage carries no reset; the pointers and counters define validity.
    always_ff @(posedge clk) begin
        if (state == CAPTURE_Q && q_valid) qbuf[cap_idx] <= q_base;
        if (push) begin
            fifo_base[wr_ptr] <= r_base;
            fifo_last[wr_ptr] <= r_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            last_acc    <= 1'b0;
            err         <= 1'b0;
            S_out       <= '0;
            store_S_out <= 1'b0;
            T_out       <= '0;
            init_out    <= 1'b0;
        end else begin
            store_S_out <= 1'b0;
            init_out    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err        <= 1'b0;
                        cnt        <= '0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        fifo_count <= '0;
                        last_acc   <= 1'b0;
                    end
                end
                CAPTURE_Q: begin
                    if (q_valid) cnt <= (cnt == LOAD_LAST) ? '0 : cnt + CW'(1);
                end
                LOAD_Q: begin
                    store_S_out <= 1'b1;
                    S_out       <= qbuf[load_idx];
                    cnt         <= (cnt == LOAD_LAST) ? '0 : cnt + CW'(1);
                end
                STREAM: begin
                    // The drain count starts one higher on underflow, because init_out
                    // already drops on that edge; done then trails the fall equally.
                    if (pop) begin
                        T_out    <= fifo_base[rd_ptr];
                        init_out <= 1'b1;
                        rd_ptr   <= rd_ptr + AW'(1);
                        if (pop_last) cnt <= '0;
                    end else begin
                        err <= 1'b1;
                        cnt <= CW'(1);
                    end
                end
                DRAIN: begin
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (r_last) last_acc <= 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + (AW + 1)'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - (AW + 1)'(1);
            end
        end
    end

endmodule
